// File: rtl/sync_down_counter_pkg.sv
// Shared types and defaults for the loadable down counter and its prescaler.
package sync_down_counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH    = 4;
  localparam int DEF_PRESCALE = 4;

endpackage

// File: rtl/sync_down_counter_tick_gen.sv
// Count-tick prescaler: tick is high for one cycle out of every PRESCALE
// enabled cycles, counted from the last clear.
module cnt_tick_gen #(
  parameter int PRESCALE = sync_down_counter_pkg::DEF_PRESCALE
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(PRESCALE);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == CW'(PRESCALE - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sync_down_counter.sv
// Loadable down counter with terminal-count pulse and optional auto-reload.
// Define CNT_PRESCALE_EN to slow the count tick to one per PRESCALE cycles.
module sync_down_counter
  import sync_down_counter_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] rld_q, rld_d;
  logic             tc_q, tc_d;
  logic             tick;

`ifdef CNT_PRESCALE_EN
  logic run_entry;

  // The prescaler restarts whenever RUN is entered, so the first decrement
  // always lands PRESCALE edges after the start.
  assign run_entry = (state_d == RUN) && (state_q != RUN);

  cnt_tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .clr  (load || run_entry),
    .en   (state_q == RUN),
    .tick (tick)
  );
`else
  localparam int unused_prescale = PRESCALE;
  assign tick = 1'b1;
`endif

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    q_d     = q_q;
    rld_d   = rld_q;
    state_d = state_q;
    tc_d    = 1'b0;
    if (load) begin
      q_d     = load_val;
      rld_d   = load_val;
      state_d = IDLE;
    end else if (stop) begin
      if (state_q == RUN) state_d = IDLE;
    end else if (start && (state_q == IDLE)) begin
      if (q_q != '0) begin
        state_d = RUN;
      end else begin
        tc_d    = 1'b1;
        state_d = DONE;
      end
    end else if (start && (state_q == DONE)) begin
      if (rld_q != '0) begin
        q_d     = rld_q;
        state_d = RUN;
      end else begin
        tc_d = 1'b1;
      end
    end else if ((state_q == RUN) && tick) begin
      if (q_q > WIDTH'(1)) begin
        q_d = q_q - WIDTH'(1);
      end else begin
        // q==0 in RUN is unreachable; it stops in DONE rather than wrapping.
        tc_d = (q_q != '0);
        if (auto_reload && (q_q != '0)) begin
          q_d = rld_q;
        end else begin
          q_d     = '0;
          state_d = DONE;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q_q     <= '0;
      rld_q   <= '0;
      state_q <= IDLE;
      tc_q    <= 1'b0;
    end else begin
      q_q     <= q_d;
      rld_q   <= rld_d;
      state_q <= state_d;
      tc_q    <= tc_d;
    end
  end

  assign q    = q_q;
  assign qb   = ~q_q;
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign tc   = tc_q;

endmodule
